// File: rtl/video_pkg.sv
// Shared timing constants for the 8 MHz monochrome video path.
// PIPE_DELAY is also used by the video RAM fetch/shift stage.
package video_pkg;

  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int V_W = 9;

  localparam int PIPE_DELAY = 2;

  localparam int H_VISIBLE_DEF    = 320;
  localparam int H_TOTAL_DEF      = 512;
  localparam int H_SYNC_START_DEF = 384;
  localparam int H_SYNC_WIDTH_DEF = 38;
  localparam int V_VISIBLE_DEF    = 200;
  localparam int V_TOTAL_DEF      = 312;
  localparam int V_SYNC_START_DEF = 256;
  localparam int V_SYNC_WIDTH_DEF = 3;

  function automatic bit windowFits(int start, int width, int total);
    return (start + width) <= total;
  endfunction

endpackage

// File: rtl/delay_line.sv
// Parameterised shift register with async active-low clear; DEPTH=0 is a wire.
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
          stages[0] <= din;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: pixel coordinates, visible window, syncs aligned
// to the fetch/shift latency, and a one-shot vertical-blank interrupt.
module video_timing
  import video_pkg::*;
#(
  parameter int H_VISIBLE    = H_VISIBLE_DEF,
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int H_SYNC_START = H_SYNC_START_DEF,
  parameter int H_SYNC_WIDTH = H_SYNC_WIDTH_DEF,
  parameter int V_VISIBLE    = V_VISIBLE_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int V_SYNC_START = V_SYNC_START_DEF,
  parameter int V_SYNC_WIDTH = V_SYNC_WIDTH_DEF,
  parameter int SYNC_DELAY   = PIPE_DELAY
) (
  input  logic           clk,
  input  logic           resetN,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           visible,
  output logic           hsync,
  output logic           vsync,
  output logic           hsyncDelayed,
  output logic           vsyncDelayed,
  output logic           irqVblank,
  input  logic           irqAck,
  output logic           irqPending
);

  if (!windowFits(H_SYNC_START, H_SYNC_WIDTH, H_TOTAL)) begin : g_hsync_chk
    $error("video_timing: hsync window exceeds H_TOTAL");
  end
  if (!windowFits(V_SYNC_START, V_SYNC_WIDTH, V_TOTAL)) begin : g_vsync_chk
    $error("video_timing: vsync window exceeds V_TOTAL");
  end
  if (H_TOTAL > 512 || V_TOTAL > 512 || V_VISIBLE > 256) begin : g_size_chk
    $error("video_timing: raster size exceeds counter widths");
  end

  logic [X_W-1:0] hCount;
  logic [V_W-1:0] vCount;
  logic           running;
  logic           lineEnd;
  logic           frameEnd;
  logic           vblankNext;
  logic [1:0]     syncDly;

  assign lineEnd    = (int'(hCount) == H_TOTAL - 1);
  assign frameEnd   = (int'(vCount) == V_TOTAL - 1);
  assign vblankNext = running && lineEnd && (int'(vCount) == V_VISIBLE - 1);

  // Counters hold on the edge that starts the generator, then free-run.
  // irqPending is also re-set while the pulse is high, so an ack that
  // overlaps the pulse never loses the interrupt.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hCount     <= '0;
      vCount     <= '0;
      running    <= 1'b0;
      irqVblank  <= 1'b0;
      irqPending <= 1'b0;
    end else begin
      running <= 1'b1;
      if (running) begin
        if (lineEnd) begin
          hCount <= '0;
          vCount <= frameEnd ? '0 : vCount + 1'b1;
        end else begin
          hCount <= hCount + 1'b1;
        end
      end
      irqVblank  <= vblankNext;
      irqPending <= vblankNext | irqVblank | (irqPending & ~irqAck);
    end
  end

  assign x       = hCount;
  assign y       = vCount[Y_W-1:0];
  assign visible = running && (int'(hCount) < H_VISIBLE) && (int'(vCount) < V_VISIBLE);
  assign hsync   = running && (int'(hCount) >= H_SYNC_START)
                           && (int'(hCount) <  H_SYNC_START + H_SYNC_WIDTH);
  assign vsync   = running && (int'(vCount) >= V_SYNC_START)
                           && (int'(vCount) <  V_SYNC_START + V_SYNC_WIDTH);

  delay_line #(
    .WIDTH(2),
    .DEPTH(SYNC_DELAY)
  ) u_sync_delay (
    .clk   (clk),
    .resetN(resetN),
    .din   ({hsync, vsync}),
    .dout  (syncDly)
  );

  assign hsyncDelayed = syncDly[1];
  assign vsyncDelayed = syncDly[0];

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing: reference model of the raster plus
// a vector table and hand-written sequences for wrap, sync, irq and reset.
module tb_video_timing;

  localparam int HV = 320, HT = 512, HSS = 384, HSW = 38;
  localparam int VV = 20, VT = 32, VSS = 24, VSW = 3;
  localparam int PD = 2;

  logic       clk = 1'b0;
  logic       resetN;
  logic       irqAck;
  logic [8:0] x;
  logic [7:0] y;
  logic       visible, hsync, vsync, hsyncDelayed, vsyncDelayed;
  logic       irqVblank, irqPending;
  logic [23:0] dutVec;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       ack;
    logic [8:0] x;
    logic [7:0] y;
    logic       vis;
  } vec_t;
  vec_t vecs[$];

  // Reference model state: cycles elapsed in the frame, not counters.
  bit         mRunning;
  int         mT;
  logic       mIrq, mPending;
  logic [1:0] dlyQ[$];
  logic [1:0] mDly;

  video_timing #(
    .H_VISIBLE(HV), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
    .V_VISIBLE(VV), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW),
    .SYNC_DELAY(PD)
  ) dut (
    .clk(clk), .resetN(resetN), .x(x), .y(y), .visible(visible),
    .hsync(hsync), .vsync(vsync), .hsyncDelayed(hsyncDelayed),
    .vsyncDelayed(vsyncDelayed), .irqVblank(irqVblank), .irqAck(irqAck),
    .irqPending(irqPending)
  );

  always #5 clk = ~clk;

  assign dutVec = {x, y, visible, hsync, vsync, hsyncDelayed, vsyncDelayed, irqVblank, irqPending};

  function automatic int mH();
    return mT % HT;
  endfunction

  function automatic int mV();
    return (mT / HT) % VT;
  endfunction

  function automatic logic [1:0] mSync();
    int h, v;
    h = mH();
    v = mV();
    return {mRunning && h >= HSS && h < HSS + HSW, mRunning && v >= VSS && v < VSS + VSW};
  endfunction

  function automatic logic [23:0] modelOut();
    int h, v;
    logic [1:0] s;
    h = mH();
    v = mV();
    s = mSync();
    return {9'(h), 8'(v), mRunning && h < HV && v < VV, s, mDly, mIrq, mPending};
  endfunction

  task automatic modelReset();
    mRunning = 0;
    mT       = 0;
    mIrq     = 1'b0;
    mPending = 1'b0;
    mDly     = 2'b00;
    dlyQ     = {};
    for (int i = 0; i < PD; i++) dlyQ.push_back(2'b00);
  endtask

  task automatic modelEdge();
    logic prevIrq;
    bit   advanced;
    if (!resetN) begin
      modelReset();
      return;
    end
    prevIrq  = mIrq;
    advanced = mRunning;
    if (mRunning) mT = (mT + 1) % (HT * VT);
    else mRunning = 1;
    mIrq     = advanced && mH() == 0 && mV() == VV;
    mPending = mIrq || prevIrq || (mPending && !irqAck);
    dlyQ.push_back(mSync());
    mDly = dlyQ.pop_front();
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [23:0] exp;
    exp = modelOut();
    checks++;
    if (dutVec !== exp) begin
      errors++;
      $display("[TB] FAIL model t=%0t: got %h expected %h", $time, dutVec, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic a);
    resetN = r;
    irqAck = a;
    if (!r) modelReset();
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic runTable();
    logic wasReset;
    for (int i = 0; i < vecs.size(); i++) begin
      wasReset = !resetN;
      applyStimulus(vecs[i].rst, vecs[i].ack);
      if (wasReset && vecs[i].rst) begin
        #2;
        checkVal("hold_before_first_edge", int'(dutVec), 0);
      end
      tick();
      checkVal($sformatf("table%0d_x", i), int'(x), int'(vecs[i].x));
      checkVal($sformatf("table%0d_y", i), int'(y), int'(vecs[i].y));
      checkVal($sformatf("table%0d_visible", i), int'(visible), int'(vecs[i].vis));
    end
  endtask

  initial begin
    bit found;
    int n, visCnt, visOk, hsCnt, hsFirst, hRise, hdRise, vsCnt, vsRise, vdRise, irqCnt, irqAt, rstHold;
    logic prevHs, prevHd, prevVs, prevVd;

    vecs.push_back('{1'b0, 1'b0, 9'd0, 8'd0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 9'd0, 8'd0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 9'd0, 8'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 9'd0, 8'd0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 9'd1, 8'd0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 9'd2, 8'd0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 9'd3, 8'd0, 1'b1});

    $display("[TB] reset release");
    applyStimulus(1'b0, 1'b0);
    repeat (2) tick();
    runTable();

    $display("[TB] line wrap");
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick();
      found = (x == 9'd511);
    end
    checkVal("reach_x511", int'(found), 1);
    tick();
    checkVal("wrap_x", int'(x), 0);
    checkVal("wrap_y", int'(y), 1);
    visCnt = 0; visOk = 0; hsCnt = 0; hsFirst = -1; hRise = -1; hdRise = -1;
    prevHs = hsync; prevHd = hsyncDelayed;
    for (int i = 0; i < HT; i++) begin
      if (visible) visCnt++;
      if (visible == (int'(x) < HV)) visOk++;
      if (hsync) hsCnt++;
      if (hsync && !prevHs) begin hsFirst = int'(x); hRise = i; end
      if (hsyncDelayed && !prevHd) hdRise = i;
      prevHs = hsync; prevHd = hsyncDelayed;
      tick();
    end
    checkVal("line_visible_count", visCnt, HV);
    checkVal("line_visible_window", visOk, HT);
    checkVal("hsync_length", hsCnt, HSW);
    checkVal("hsync_start_x", hsFirst, HSS);
    checkVal("hsync_delay", hdRise - hRise, PD);

    $display("[TB] frame wrap");
    found = 0;
    for (int i = 0; i < 20000 && !found; i++) begin
      tick();
      found = visible && x == 9'd0 && y == 8'd0;
    end
    checkVal("reach_frame_start", int'(found), 1);
    n = 0; vsCnt = 0; visCnt = 0; irqCnt = 0; irqAt = -1; vsRise = -1; vdRise = -1;
    prevVs = vsync; prevVd = vsyncDelayed; found = 0;
    while (!found && n < 20000) begin
      if (vsync) vsCnt++;
      if (vsync && !prevVs) vsRise = n;
      if (vsyncDelayed && !prevVd) vdRise = n;
      if (visible) visCnt++;
      if (irqVblank) begin irqCnt++; irqAt = n; end
      prevVs = vsync; prevVd = vsyncDelayed;
      tick();
      n++;
      found = visible && x == 9'd0 && y == 8'd0;
    end
    checkVal("frame_period", n, HT * VT);
    checkVal("vsync_length", vsCnt, VSW * HT);
    checkVal("vsync_start", vsRise, VSS * HT);
    checkVal("vsync_delay", vdRise - vsRise, PD);
    checkVal("frame_visible_count", visCnt, HV * VV);
    checkVal("irq_per_frame", irqCnt, 1);
    checkVal("irq_position", irqAt, VV * HT);
    checkVal("pending_held", int'(irqPending), 1);

    $display("[TB] interrupt acknowledge");
    applyStimulus(1'b1, 1'b1);
    tick();
    n = 1;
    checkVal("ack_clears", int'(irqPending), 0);
    applyStimulus(1'b1, 1'b0);
    while (n < VV * HT - 1) begin
      tick();
      n++;
    end
    checkVal("no_early_irq", int'(irqVblank), 0);
    applyStimulus(1'b1, 1'b1);
    tick();
    checkVal("irq_pulse", int'(irqVblank), 1);
    checkVal("irq_pending_set", int'(irqPending), 1);
    tick();
    checkVal("irq_one_clock", int'(irqVblank), 0);
    checkVal("ack_with_irq_set_wins", int'(irqPending), 1);
    applyStimulus(1'b1, 1'b0);
    tick();
    checkVal("pending_sticky", int'(irqPending), 1);
    applyStimulus(1'b1, 1'b1);
    tick();
    checkVal("ack_late_clears", int'(irqPending), 0);
    applyStimulus(1'b1, 1'b0);

    $display("[TB] async reset mid-frame");
    found = 0;
    for (int i = 0; i < 20000 && !found; i++) begin
      tick();
      found = visible && y == 8'd10 && x == 9'd50;
    end
    checkVal("reach_v10_h50", int'(found), 1);
    #2;
    applyStimulus(1'b0, 1'b0);
    #1;
    checkVal("async_reset_zero", int'(dutVec), 0);
    checkOutput();
    runTable();

    $display("[TB] randomized run");
    rstHold = 0;
    for (int i = 0; i < 8000; i++) begin
      if (rstHold > 0) begin
        rstHold--;
        applyStimulus(1'b0, $urandom_range(0, 1) == 0);
      end else if ($urandom_range(0, 1999) == 0) begin
        rstHold = $urandom_range(0, 2);
        applyStimulus(1'b0, 1'b0);
      end else begin
        applyStimulus(1'b1, $urandom_range(0, 7) == 0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
